pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline registers, with divider start/abort handshake.
// Outputs are combinational from state and inputs; state, redirect flag and stall counter update on clk.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lw_use_haz,
    input  logic             div_req,
    input  logic             div_done,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             exc_flush,
    input  logic             cnt_clr,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             div_start,
    output logic             div_abort,
    output logic             exc_pc_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             redir_q, redir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_taken;

    assign exc_taken = exc_flush & ~dmem_busy;

    always_comb begin
        en_f       = 1'b1;
        en_d       = 1'b1;
        en_e       = 1'b1;
        en_m       = 1'b1;
        en_w       = 1'b1;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        flush_w    = 1'b0;
        div_start  = 1'b0;
        div_abort  = 1'b0;
        exc_pc_sel = redir_q;
        state_d    = state_q;
        redir_d    = redir_q;

        if (dmem_busy) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            en_m    = 1'b0;
            flush_w = 1'b1;
        end else if (exc_flush) begin
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            flush_m    = 1'b1;
            flush_w    = 1'b1;
            exc_pc_sel = 1'b1;
            en_f       = ~imem_busy;
            div_abort  = (state_q != RUN);
            state_d    = RUN;
        end else if ((state_q == RUN && div_req) || (state_q == DIV_BUSY && !div_done)) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            flush_m = 1'b1;
            if (state_q == RUN) begin
                div_start = 1'b1;
                state_d   = DIV_BUSY;
            end
        end else if (lw_use_haz) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
        end else if (imem_busy) begin
            en_f    = 1'b0;
            flush_d = 1'b1;
        end

        // A finished divide stays parked until its instruction actually leaves E.
        if (!exc_taken && (state_q == DIV_HOLD || (state_q == DIV_BUSY && div_done))) begin
            state_d = en_e ? RUN : DIV_HOLD;
        end

        if (exc_taken && imem_busy) begin
            redir_d = 1'b1;
        end else if (en_f) begin
            redir_d = 1'b0;
        end

        if (rst) begin
            en_f       = 1'b0;
            en_d       = 1'b0;
            en_e       = 1'b0;
            en_m       = 1'b0;
            en_w       = 1'b0;
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            flush_m    = 1'b1;
            flush_w    = 1'b1;
            div_start  = 1'b0;
            div_abort  = 1'b0;
            exc_pc_sel = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (!en_d && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            redir_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a source-priority reference model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lw_use_haz = 1'b0, div_req = 1'b0, div_done = 1'b0;
    logic             imem_busy = 1'b0, dmem_busy = 1'b0, exc_flush = 1'b0, cnt_clr = 1'b0;
    logic             en_f, en_d, en_e, en_m, en_w;
    logic             flush_d, flush_e, flush_m, flush_w;
    logic             div_start, div_abort, exc_pc_sel;
    logic [CNT_W-1:0] stall_cycles;
    logic [11:0]      dut_o;
    logic [11:0]      last_obs;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: is a divide in flight, is a finished one parked in E, is a redirect owed.
    bit m_running, m_parked, m_owed;
    int m_stalls;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .lw_use_haz(lw_use_haz), .div_req(div_req), .div_done(div_done),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .exc_flush(exc_flush), .cnt_clr(cnt_clr),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .div_start(div_start), .div_abort(div_abort), .exc_pc_sel(exc_pc_sel),
        .stall_cycles(stall_cycles)
    );

    assign dut_o = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, flush_w,
                    div_start, div_abort, exc_pc_sel};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int winner();
        if (dmem_busy) return 1;
        if (exc_flush) return 2;
        if ((div_req && !m_running && !m_parked) || (m_running && !div_done)) return 3;
        if (lw_use_haz) return 4;
        if (imem_busy) return 5;
        return 0;
    endfunction

    // Packing: {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m,flush_w, start,abort,pc_sel}
    function automatic logic [11:0] model_out();
        logic [4:0] en;
        logic [3:0] fl;
        logic       st, ab, pc;
        if (rst) return {5'b00000, 4'b1111, 3'b000};
        en = 5'b11111;
        fl = 4'b0000;
        st = 1'b0;
        ab = 1'b0;
        pc = m_owed;
        case (winner())
            1: begin en = 5'b00001; fl = 4'b0001; end
            2: begin en = {~imem_busy, 4'b1111}; fl = 4'b1111; pc = 1'b1; ab = m_running | m_parked; end
            3: begin en = 5'b00011; fl = 4'b0010; st = !m_running; end
            4: begin en = 5'b00111; fl = 4'b0100; end
            5: begin en = 5'b01111; fl = 4'b1000; end
            default: ;
        endcase
        return {en, fl, st, ab, pc};
    endfunction

    task automatic model_step();
        logic [11:0] o;
        int          w;
        o = model_out();
        w = winner();
        if (cnt_clr) m_stalls = 0;
        else if (!o[10] && m_stalls < CNT_MAX) m_stalls++;
        if (w == 2) begin
            m_running = 0;
            m_parked  = 0;
            m_owed    = imem_busy;
        end else begin
            if (o[11]) m_owed = 0;
            if (w == 3 && !m_running) begin
                m_running = 1;
            end else if ((m_running && div_done) || m_parked) begin
                m_running = 0;
                m_parked  = !o[9];
            end
        end
    endtask

    task automatic cyc(input logic lw, input logic dq, input logic dd, input logic im,
                       input logic dm, input logic ex, input logic cl);
        lw_use_haz = lw; div_req = dq; div_done = dd; imem_busy = im;
        dmem_busy = dm; exc_flush = ex; cnt_clr = cl;
        #2;
        last_obs = dut_o;
        chk("outputs", dut_o, model_out());
        chk("stall_cycles", stall_cycles, m_stalls);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_outputs", dut_o, {5'b00000, 4'b1111, 3'b000});
        chk("rst_cnt", stall_cycles, 0);
        m_running = 0; m_parked = 0; m_owed = 0; m_stalls = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Load-use for one cycle.
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lu_pattern", last_obs, {5'b00111, 4'b0100, 3'b000});
        chk("lu_cnt", stall_cycles, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Divide: request at cycle 0, done at cycle 5.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("div_start0", last_obs, {5'b00011, 4'b0010, 3'b100});
        for (int i = 1; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("div_done_en", last_obs, {5'b11111, 4'b0000, 3'b000});
        chk("div_cnt", stall_cycles, 5);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Divide completing under a data-memory stall.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0);
        chk("hold_pattern", last_obs, {5'b00001, 4'b0001, 3'b000});
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("hold_release", last_obs, {5'b11111, 4'b0000, 3'b000});
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("next_div_start", last_obs[2], 1);
        cyc(0, 1, 1, 0, 0, 0, 0);

        // Exception in the middle of a divide.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        chk("exc_abort", last_obs, {5'b11111, 4'b1111, 3'b011});
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Exception while fetch stays busy for three cycles.
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("redir_owed", last_obs, {5'b01111, 4'b1000, 3'b001});
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("redir_last", last_obs, {5'b11111, 4'b0000, 3'b001});
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("redir_done", last_obs[0], 0);

        // Priority: data-memory wait hides exception and load-use.
        cyc(1, 0, 0, 0, 1, 1, 0);
        chk("prio", last_obs, {5'b00001, 4'b0001, 3'b000});

        // Saturation, then clear while stalled.
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("sat", stall_cycles, CNT_MAX);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("clr", stall_cycles, 0);

        // Reset mid-divide returns to RUN with a fresh counter.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rst_div_start", last_obs[2:1], 2'b10);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
